// File: rtl/stdlib_queue_pkg.sv
// ----------------------------------------------------------------------------
// stdlib_queue_pkg
// Shared definitions for the tagged queue that sits behind the 4-input
// priority arbiter.
//   - Default payload/tag/depth localparams (arbiter io_out_bits / io_chosen).
//   - entry_t : one stored beat, {tag, bits}.
//   - ptr_w() / count_w() : pointer and occupancy widths for a given depth.
// ----------------------------------------------------------------------------
package stdlib_queue_pkg;

  localparam int QUEUE_DATA_W = 8;
  localparam int QUEUE_TAG_W  = 2;
  localparam int QUEUE_DEPTH  = 4;

  typedef struct packed {
    logic [QUEUE_TAG_W-1:0]  tag;
    logic [QUEUE_DATA_W-1:0] bits;
  } entry_t;

  // Pointer width: indexes DEPTH entries, wraps naturally for power-of-two depth.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy width: must represent 0..DEPTH inclusive.
  function automatic int count_w(input int depth);
    return ptr_w(depth) + 1;
  endfunction

endpackage : stdlib_queue_pkg

// File: rtl/stdlib_queue_mem.sv
// ----------------------------------------------------------------------------
// stdlib_queue_mem
// DEPTH x entry register array with one synchronous write port and one
// asynchronous (combinational) read port.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   entry to store
//   raddr  in   read address
//   rdata  out  entry at raddr (combinational)
// ----------------------------------------------------------------------------
module stdlib_queue_mem
  import stdlib_queue_pkg::*;
#(
  parameter int  DEPTH      = QUEUE_DEPTH,
  parameter type entry_type = entry_t
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [ptr_w(DEPTH)-1:0]   waddr,
  input  entry_type                 wdata,
  input  logic [ptr_w(DEPTH)-1:0]   raddr,
  output entry_type                 rdata
);

  entry_type storage [DEPTH];

  // NOTE: storage has no reset; validity is tracked by the pointers, so
  // clearing contents would only cost reset fan-out without changing behaviour.
  always_ff @(posedge clk) begin
    if (we) begin
      storage[waddr] <= wdata;
    end
  end

  assign rdata = storage[raddr];

endmodule : stdlib_queue_mem

// File: rtl/stdlib_tagged_queue.sv
// ----------------------------------------------------------------------------
// stdlib_tagged_queue
// Decoupled FIFO directly downstream of the 4-input priority arbiter. Each
// granted beat is stored with its source tag so the arbiter sees ready while
// the consumer stalls. Order and tags are preserved; occupancy is exported.
//
// Optional feature: define STDLIB_TAGGED_QUEUE_FLOW_EN for a combinational
// bypass when the queue is empty (zero-latency pass-through). io_enq_ready is
// the same in both builds.
//
// Ports:
//   clk           in   clock
//   reset         in   synchronous, active-high reset
//   io_enq_valid  in   arbiter io_out_valid
//   io_enq_ready  out  to arbiter io_out_ready (depends on state only)
//   io_enq_bits   in   arbiter io_out_bits
//   io_enq_tag    in   arbiter io_chosen
//   io_deq_valid  out  beat available
//   io_deq_ready  in   consumer accepts
//   io_deq_bits   out  head payload
//   io_deq_tag    out  head source tag
//   io_count      out  entries held, 0..DEPTH
// ----------------------------------------------------------------------------
module stdlib_tagged_queue
  import stdlib_queue_pkg::*;
#(
  parameter int DATA_W = QUEUE_DATA_W,
  parameter int TAG_W  = QUEUE_TAG_W,
  parameter int DEPTH  = QUEUE_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      io_enq_valid,
  output logic                      io_enq_ready,
  input  logic [DATA_W-1:0]         io_enq_bits,
  input  logic [TAG_W-1:0]          io_enq_tag,
  output logic                      io_deq_valid,
  input  logic                      io_deq_ready,
  output logic [DATA_W-1:0]         io_deq_bits,
  output logic [TAG_W-1:0]          io_deq_tag,
  output logic [count_w(DEPTH)-1:0] io_count
);

  localparam int PTR_W   = ptr_w(DEPTH);
  localparam int COUNT_W = count_w(DEPTH);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] bits;
  } q_entry_t;

  logic [PTR_W-1:0] enq_ptr;
  logic [PTR_W-1:0] deq_ptr;
  logic             maybe_full;

  logic     ptr_match;
  logic     empty;
  logic     full;
  logic     do_enq;
  logic     do_deq;
  logic     bypass;
  logic     push;
  logic     pop;
  q_entry_t wr_entry;
  q_entry_t head;
  logic [PTR_W-1:0] ptr_diff;

  // Equal pointers are ambiguous; maybe_full records whether the last
  // pointer-moving cycle was a net enqueue (full) or a net dequeue (empty).
  assign ptr_match = (enq_ptr == deq_ptr);
  assign empty     = ptr_match & ~maybe_full;
  assign full      = ptr_match &  maybe_full;

  // Ready comes from state alone so no ready chain forms through the arbiter.
  assign io_enq_ready = ~full;

  assign do_enq = io_enq_valid & io_enq_ready;
  assign do_deq = io_deq_valid & io_deq_ready;

`ifdef STDLIB_TAGGED_QUEUE_FLOW_EN
  // Empty queue forwards the incoming beat; if it is consumed in the same
  // cycle it never touches storage.
  assign bypass       = empty & io_enq_valid & io_deq_ready;
  assign io_deq_valid = empty ? io_enq_valid : 1'b1;
  assign io_deq_bits  = empty ? io_enq_bits  : head.bits;
  assign io_deq_tag   = empty ? io_enq_tag   : head.tag;
`else
  assign bypass       = 1'b0;
  assign io_deq_valid = ~empty;
  assign io_deq_bits  = head.bits;
  assign io_deq_tag   = head.tag;
`endif

  // A bypassed beat is neither written nor popped from storage.
  assign push = do_enq & ~bypass;
  assign pop  = do_deq & ~empty;

  assign wr_entry.tag  = io_enq_tag;
  assign wr_entry.bits = io_enq_bits;

  stdlib_queue_mem #(
    .DEPTH      (DEPTH),
    .entry_type (q_entry_t)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (enq_ptr),
    .wdata (wr_entry),
    .raddr (deq_ptr),
    .rdata (head)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      enq_ptr    <= '0;
      deq_ptr    <= '0;
      maybe_full <= 1'b0;
    end else begin
      if (push) begin
        enq_ptr <= enq_ptr + PTR_W'(1);
      end
      if (pop) begin
        deq_ptr <= deq_ptr + PTR_W'(1);
      end
      if (push != pop) begin
        maybe_full <= push;
      end
    end
  end

  // Pointer difference wraps modulo DEPTH; full is the one case it cannot show.
  assign ptr_diff = enq_ptr - deq_ptr;
  assign io_count = full ? COUNT_W'(DEPTH) : {1'b0, ptr_diff};

endmodule : stdlib_tagged_queue

// File: tb/tb_stdlib_tagged_queue.sv
// ----------------------------------------------------------------------------
// tb_stdlib_tagged_queue
// Directed bench for stdlib_tagged_queue with a queue-level reference model
// compared every cycle, plus literal expectations for the key scenarios.
// Honors STDLIB_TAGGED_QUEUE_FLOW_EN when defined for the build.
// ----------------------------------------------------------------------------
module tb_stdlib_tagged_queue;

  localparam int DATA_W = 8;
  localparam int TAG_W  = 2;
  localparam int DEPTH  = 4;
`ifdef STDLIB_TAGGED_QUEUE_FLOW_EN
  localparam bit FLOW = 1'b1;
`else
  localparam bit FLOW = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              io_enq_valid;
  logic              io_enq_ready;
  logic [DATA_W-1:0] io_enq_bits;
  logic [TAG_W-1:0]  io_enq_tag;
  logic              io_deq_valid;
  logic              io_deq_ready;
  logic [DATA_W-1:0] io_deq_bits;
  logic [TAG_W-1:0]  io_deq_tag;
  logic [2:0]        io_count;

  int n_checks = 0;
  int n_fail   = 0;

  stdlib_tagged_queue #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_enq_valid (io_enq_valid),
    .io_enq_ready (io_enq_ready),
    .io_enq_bits  (io_enq_bits),
    .io_enq_tag   (io_enq_tag),
    .io_deq_valid (io_deq_valid),
    .io_deq_ready (io_deq_ready),
    .io_deq_bits  (io_deq_bits),
    .io_deq_tag   (io_deq_tag),
    .io_count     (io_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model: a plain queue of {tag, bits} ----------
  logic [TAG_W+DATA_W-1:0] model_q[$];
  bit model_live = 1'b0;

  always @(posedge clk) begin
    bit acc_enq;
    bit pass;
    if (reset) begin
      model_q.delete();
      model_live = 1'b1;
    end else if (model_live) begin
      acc_enq = io_enq_valid && (model_q.size() < DEPTH);
      pass    = FLOW && (model_q.size() == 0) && io_enq_valid && io_deq_ready;
      if (model_q.size() > 0 && io_deq_ready) void'(model_q.pop_front());
      if (acc_enq && !pass) model_q.push_back({io_enq_tag, io_enq_bits});
    end
  end

  always @(negedge clk) begin
    logic [TAG_W+DATA_W-1:0] exp_head;
    bit exp_valid;
    if (model_live) begin
      exp_valid = (model_q.size() > 0) || (FLOW && io_enq_valid);
      exp_head  = (model_q.size() > 0) ? model_q[0] : {io_enq_tag, io_enq_bits};
      check("model enq_ready", 32'(io_enq_ready), 32'(model_q.size() < DEPTH));
      check("model deq_valid", 32'(io_deq_valid), 32'(exp_valid));
      check("model count", 32'(io_count), 32'(model_q.size()));
      if (exp_valid) begin
        check("model deq_bits", 32'(io_deq_bits), 32'(exp_head[DATA_W-1:0]));
        check("model deq_tag", 32'(io_deq_tag), 32'(exp_head[TAG_W+DATA_W-1:DATA_W]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [7:0] b, input logic [1:0] t, input bit rdy);
    io_enq_valid = v;
    io_enq_bits  = b;
    io_enq_tag   = t;
    io_deq_ready = rdy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    repeat (2) step();
    reset = 1'b0;

    // Reset state.
    check("reset enq_ready", 32'(io_enq_ready), 32'd1);
    check("reset deq_valid", 32'(io_deq_valid), 32'd0);
    check("reset count", 32'(io_count), 32'd0);

    // Idle with consumer ready: nothing to dequeue.
    drive(1'b0, 8'h00, 2'd0, 1'b1);
    repeat (3) step();
    check("idle deq_valid", 32'(io_deq_valid), 32'd0);
    check("idle count", 32'(io_count), 32'd0);

    // Fill with consumer stalled.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h11 * (i + 1)), 2'(i), 1'b0);
      step();
      check("fill count", 32'(io_count), 32'(i + 1));
    end
    check("full enq_ready", 32'(io_enq_ready), 32'd0);

    // Fifth beat stays pending while full.
    drive(1'b1, 8'h55, 2'd0, 1'b0);
    repeat (2) step();
    check("pending count", 32'(io_count), 32'd4);
    check("pending enq_ready", 32'(io_enq_ready), 32'd0);
    check("pending head bits", 32'(io_deq_bits), 32'h11);

    // Full with enq and deq both valid: only the head leaves.
    drive(1'b1, 8'h55, 2'd0, 1'b1);
    #1;
    check("drain head0 bits", 32'(io_deq_bits), 32'h11);
    check("drain head0 tag", 32'(io_deq_tag), 32'd0);
    step();
    check("full-deq count", 32'(io_count), 32'd3);
    check("full-deq enq_ready", 32'(io_enq_ready), 32'd1);
    check("drain head1 bits", 32'(io_deq_bits), 32'h22);
    check("drain head1 tag", 32'(io_deq_tag), 32'd1);
    step();  // 0x55 lands at the wrapped pointer while 0x22 leaves
    drive(1'b0, 8'h00, 2'd0, 1'b1);
    check("wrap count", 32'(io_count), 32'd3);
    check("drain head2 bits", 32'(io_deq_bits), 32'h33);
    check("drain head2 tag", 32'(io_deq_tag), 32'd2);
    step();
    check("drain head3 bits", 32'(io_deq_bits), 32'h44);
    check("drain head3 tag", 32'(io_deq_tag), 32'd3);
    step();
    check("drain head4 bits", 32'(io_deq_bits), 32'h55);
    check("drain head4 tag", 32'(io_deq_tag), 32'd0);
    check("drain count1", 32'(io_count), 32'd1);
    step();
    check("drained count", 32'(io_count), 32'd0);
    check("drained deq_valid", 32'(io_deq_valid), 32'd0);

    // Steady stream, one beat per cycle.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'(8'h80 + i), 2'(i % 4), 1'b1);
      #1;
      if (FLOW) begin
        check("flow deq_valid", 32'(io_deq_valid), 32'd1);
        check("flow deq_bits", 32'(io_deq_bits), 32'(8'h80 + i));
      end
      step();
      check("stream count", 32'(io_count), FLOW ? 32'd0 : 32'd1);
      if (!FLOW) begin
        check("stream head bits", 32'(io_deq_bits), 32'(8'h80 + i));
        check("stream head tag", 32'(io_deq_tag), 32'(i % 4));
      end
    end
    drive(1'b0, 8'h00, 2'd0, 1'b1);
    step();
    check("stream end count", 32'(io_count), 32'd0);
    check("stream end deq_valid", 32'(io_deq_valid), 32'd0);

    // Reset mid-operation with three entries held.
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 8'(i), 2'(i), 1'b0);
      step();
    end
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    check("pre-reset count", 32'(io_count), 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("post-reset count", 32'(io_count), 32'd0);
    check("post-reset deq_valid", 32'(io_deq_valid), 32'd0);
    drive(1'b1, 8'hA5, 2'd2, 1'b0);
    step();
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    check("after-reset head bits", 32'(io_deq_bits), 32'hA5);
    check("after-reset head tag", 32'(io_deq_tag), 32'd2);
    check("after-reset count", 32'(io_count), 32'd1);
    io_deq_ready = 1'b1;
    step();
    check("final count", 32'(io_count), 32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_stdlib_tagged_queue
